// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writes pass straight through, long-latency
// results queue in a 2-entry FIFO and fill idle slots or force a stall when starved.
// Optional macro WBARB_PEND_CHECK_EN enables the pending-write hazard query on qHitOut.
module wb_port_arbiter #(
   parameter int unsigned BUS_W      = 32,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pWeIn,
   input  logic [4:0]       pAddrIn,
   input  logic [BUS_W-1:0] pDataIn,
   input  logic             lValidIn,
   input  logic [4:0]       lAddrIn,
   input  logic [BUS_W-1:0] lDataIn,
   output logic             lReadyOut,
   input  logic [4:0]       qAddrIn,
   output logic             qHitOut,
   output logic             stallOut,
   output logic             regWeOut,
   output logic [4:0]       regAddrOut,
   output logic [BUS_W-1:0] regWDataOut
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   logic [4:0]       addr_q [2];
   logic [BUS_W-1:0] data_q [2];
   logic [1:0]       vld_q, vld_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             wptr_q, wptr_d;
   logic             rptr_q, rptr_d;
   logic [3:0]       starve_q, starve_d;

   logic             head_vld;
   logic [4:0]       head_addr;
   logic [BUS_W-1:0] head_data;
   logic             push, pop, stall, p_eff, head_wr;

   always_comb begin
      head_vld  = vld_q[rptr_q];
      head_addr = addr_q[rptr_q];
      head_data = data_q[rptr_q];

      // Ready comes from the registered count only; a same-cycle pop never frees a slot.
      lReadyOut = !rst && (cnt_q < 2'd2);
      push      = lValidIn && lReadyOut && (lAddrIn != 5'd0);

      stall   = !rst && head_vld && (starve_q == STARVE_LIM);
      p_eff   = !rst && pWeIn && (pAddrIn != 5'd0) && !stall;
      head_wr = !rst && head_vld && !p_eff;
      // A younger P write to the same register supersedes the queued head.
      pop     = head_wr || (p_eff && head_vld && (head_addr == pAddrIn));

      stallOut    = stall;
      regWeOut    = 1'b0;
      regAddrOut  = 5'd0;
      regWDataOut = '0;
      if (head_wr) begin
         regWeOut    = 1'b1;
         regAddrOut  = head_addr;
         regWDataOut = head_data;
      end else if (p_eff) begin
         regWeOut    = 1'b1;
         regAddrOut  = pAddrIn;
         regWDataOut = pDataIn;
      end
   end

   always_comb begin
      vld_d  = vld_q;
      wptr_d = wptr_q ^ push;
      rptr_d = rptr_q ^ pop;
      cnt_d  = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
      if (pop)  vld_d[rptr_q] = 1'b0;
      if (push) vld_d[wptr_q] = 1'b1;

      starve_d = starve_q;
      if (!head_vld || pop)
         starve_d = 4'd0;
      else if (starve_q != STARVE_LIM)
         starve_d = starve_q + 4'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q    <= 2'b00;
         cnt_q    <= 2'd0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         starve_q <= 4'd0;
      end else begin
         vld_q    <= vld_d;
         cnt_q    <= cnt_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         starve_q <= starve_d;
      end
   end

   // Payload storage carries no reset; validity is tracked by vld_q alone.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wptr_q] <= lAddrIn;
         data_q[wptr_q] <= lDataIn;
      end
   end

`ifdef WBARB_PEND_CHECK_EN
   assign qHitOut = !rst && (qAddrIn != 5'd0) &&
                    ((vld_q[0] && (addr_q[0] == qAddrIn)) ||
                     (vld_q[1] && (addr_q[1] == qAddrIn)));
`else
   logic unused_qaddr;
   assign unused_qaddr = ^qAddrIn;
   assign qHitOut      = 1'b0;
`endif

endmodule
